// File: rtl/spec_slot_sched.sv
// Slot scheduler for the speculative write-burst pool: allocates slots, tracks data capture,
// and picks the next completed slot for the box master under same-ID, fence and divert rules.
module spec_slot_sched #(
    parameter int SLOTS  = 6,
    parameter int ID_W   = 4,
    parameter int IDX_W  = 4,
    parameter int TYPE_W = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_req,
    input  logic [ID_W-1:0]            alloc_id,
    input  logic [TYPE_W-1:0]          alloc_type,
    output logic                       alloc_gnt,
    output logic [IDX_W-1:0]           alloc_idx,
    input  logic                       done_valid,
    input  logic [IDX_W-1:0]           done_idx,
    output logic                       issue_valid,
    output logic [IDX_W-1:0]           issue_idx,
    input  logic                       issue_ready,
    input  logic                       release_valid,
    input  logic [IDX_W-1:0]           release_idx,
    output logic                       drop_valid,
    output logic [IDX_W-1:0]           drop_idx,
    output logic [$clog2(SLOTS+1)-1:0] occupancy,
    output logic                       full,
    output logic                       empty
);
    localparam int OCC_W = $clog2(SLOTS + 1);
    localparam logic [TYPE_W-1:0] T_BLOCK   = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] T_DIVERT  = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] T_UNLUCKY = TYPE_W'(3);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_FILL   = 2'd1,
        S_READY  = 2'd2,
        S_ISSUED = 2'd3
    } slot_st_e;

    slot_st_e          state_q [SLOTS];
    slot_st_e          state_d [SLOTS];
    logic [SLOTS-1:0]  age_q   [SLOTS];
    logic [SLOTS-1:0]  age_d   [SLOTS];
    logic [ID_W-1:0]   id_q    [SLOTS];
    logic [TYPE_W-1:0] type_q  [SLOTS];

    logic              issue_valid_q, issue_valid_d;
    logic [IDX_W-1:0]  issue_idx_q, issue_idx_d;
    logic              drop_valid_q, drop_valid_d;
    logic [IDX_W-1:0]  drop_idx_q, drop_idx_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              full_q, full_d, empty_q, empty_d;

    logic [SLOTS-1:0]  busy_v, live_v, elig_v, div_v, pool_v, oldest_v;
    logic              alloc_hit, issue_any, handshake;
    logic [IDX_W-1:0]  alloc_sel, issue_sel;

    always_comb begin
        alloc_hit = 1'b0;
        alloc_sel = '0;
        for (int i = 0; i < SLOTS; i++) begin
            busy_v[i] = (state_q[i] != S_FREE);
            live_v[i] = (state_q[i] == S_FILL) || (state_q[i] == S_READY);
        end
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (state_q[i] == S_FREE) begin
                alloc_hit = 1'b1;
                alloc_sel = IDX_W'(i);
            end
        end
    end

    assign alloc_gnt = alloc_req & ~full_q & alloc_hit & ~rst;
    assign alloc_idx = alloc_gnt ? alloc_sel : '0;
    assign handshake = issue_valid_q & issue_ready;

    // A READY slot waits behind any older live same-ID slot and any older occupied BLOCK slot.
    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            elig_v[i] = (state_q[i] == S_READY) && (type_q[i] != T_UNLUCKY);
            for (int j = 0; j < SLOTS; j++) begin
                if (j != i && age_q[j][i]) begin
                    if (live_v[j] && (id_q[j] == id_q[i])) elig_v[i] = 1'b0;
                    if (busy_v[j] && (type_q[j] == T_BLOCK)) elig_v[i] = 1'b0;
                end
            end
            div_v[i] = elig_v[i] && (type_q[i] == T_DIVERT);
        end
        pool_v    = (|div_v) ? div_v : elig_v;
        issue_any = |elig_v;
        issue_sel = '0;
        for (int i = 0; i < SLOTS; i++) begin
            oldest_v[i] = pool_v[i];
            for (int j = 0; j < SLOTS; j++) begin
                if (j != i && pool_v[j] && age_q[j][i]) oldest_v[i] = 1'b0;
            end
        end
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (oldest_v[i]) issue_sel = IDX_W'(i);
        end
    end

    always_comb begin
        state_d       = state_q;
        age_d         = age_q;
        drop_valid_d  = 1'b0;
        drop_idx_d    = '0;
        issue_valid_d = issue_valid_q;
        issue_idx_d   = issue_idx_q;
        occ_d         = '0;

        if (issue_valid_q) begin
            if (issue_ready) begin
                issue_valid_d = 1'b0;
                issue_idx_d   = '0;
            end
        end else begin
            issue_valid_d = issue_any;
            issue_idx_d   = issue_any ? issue_sel : '0;
        end

        for (int i = 0; i < SLOTS; i++) begin
            if (done_valid && done_idx == IDX_W'(i) && state_q[i] == S_FILL) begin
                if (type_q[i] == T_UNLUCKY) begin
                    state_d[i]   = S_FREE;
                    drop_valid_d = 1'b1;
                    drop_idx_d   = IDX_W'(i);
                end else begin
                    state_d[i] = S_READY;
                end
            end
            if (handshake && issue_idx_q == IDX_W'(i)) state_d[i] = S_ISSUED;
            if (release_valid && release_idx == IDX_W'(i) && state_q[i] == S_ISSUED)
                state_d[i] = S_FREE;
            // New slot is younger than everything currently occupied.
            if (alloc_gnt && alloc_sel == IDX_W'(i)) begin
                state_d[i] = S_FILL;
                age_d[i]   = '0;
                for (int j = 0; j < SLOTS; j++) age_d[j][i] = busy_v[j];
            end
        end

        for (int i = 0; i < SLOTS; i++) begin
            if (state_d[i] != S_FREE) occ_d = occ_d + OCC_W'(1);
        end
        full_d  = (occ_d == OCC_W'(SLOTS));
        empty_d = (occ_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                state_q[i] <= S_FREE;
                age_q[i]   <= '0;
            end
            issue_valid_q <= 1'b0;
            issue_idx_q   <= '0;
            drop_valid_q  <= 1'b0;
            drop_idx_q    <= '0;
            occ_q         <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            age_q         <= age_d;
            issue_valid_q <= issue_valid_d;
            issue_idx_q   <= issue_idx_d;
            drop_valid_q  <= drop_valid_d;
            drop_idx_q    <= drop_idx_d;
            occ_q         <= occ_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
        end
    end

    // Slot attributes are only meaningful while the slot is occupied.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SLOTS; i++) begin
            if (alloc_gnt && alloc_sel == IDX_W'(i)) begin
                id_q[i]   <= alloc_id;
                type_q[i] <= alloc_type;
            end
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_idx   = issue_idx_q;
    assign drop_valid  = drop_valid_q;
    assign drop_idx    = drop_idx_q;
    assign occupancy   = occ_q;
    assign full        = full_q;
    assign empty       = empty_q;

endmodule

// File: tb/tb_spec_slot_sched.sv
// Bench for spec_slot_sched: directed scenarios plus randomized traffic against a
// queue-ordered behavioural model of the slot pool.
module tb_spec_slot_sched;
    localparam int SLOTS  = 6;
    localparam int ID_W   = 4;
    localparam int IDX_W  = 4;
    localparam int TYPE_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              alloc_req;
    logic [ID_W-1:0]   alloc_id;
    logic [TYPE_W-1:0] alloc_type;
    logic              alloc_gnt;
    logic [IDX_W-1:0]  alloc_idx;
    logic              done_valid;
    logic [IDX_W-1:0]  done_idx;
    logic              issue_valid;
    logic [IDX_W-1:0]  issue_idx;
    logic              issue_ready;
    logic              release_valid;
    logic [IDX_W-1:0]  release_idx;
    logic              drop_valid;
    logic [IDX_W-1:0]  drop_idx;
    logic [2:0]        occupancy;
    logic              full;
    logic              empty;

    int total = 0;
    int bad   = 0;

    spec_slot_sched #(.SLOTS(SLOTS), .ID_W(ID_W), .IDX_W(IDX_W), .TYPE_W(TYPE_W)) dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_id(alloc_id), .alloc_type(alloc_type),
        .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx),
        .done_valid(done_valid), .done_idx(done_idx),
        .issue_valid(issue_valid), .issue_idx(issue_idx), .issue_ready(issue_ready),
        .release_valid(release_valid), .release_idx(release_idx),
        .drop_valid(drop_valid), .drop_idx(drop_idx),
        .occupancy(occupancy), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Model: slot state 0 free, 1 filling, 2 ready, 3 issued; age kept as an oldest-first queue.
    int m_st [SLOTS];
    int m_id [SLOTS];
    int m_ty [SLOTS];
    int order[$];
    bit m_iv;
    int m_iidx;
    bit m_dv;
    int m_didx;

    function automatic int lowest_free();
        for (int s = 0; s < SLOTS; s++) if (m_st[s] == 0) return s;
        return -1;
    endfunction

    task automatic model_remove(input int s);
        for (int k = 0; k < order.size(); k++) begin
            if (order[k] == s) begin
                order.delete(k);
                return;
            end
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SLOTS; s++) m_st[s] = 0;
        order.delete();
        m_iv = 0; m_iidx = 0; m_dv = 0; m_didx = 0;
    endtask

    task automatic model_step();
        int sel_any, sel_div, hs_slot, d, r, a;
        bit hs, dn, rl, ag;
        sel_any = -1;
        sel_div = -1;
        for (int k = 0; k < order.size(); k++) begin
            int s;
            bit ok;
            s  = order[k];
            ok = (m_st[s] == 2) && (m_ty[s] != 3);
            for (int p = 0; p < k; p++) begin
                if (m_ty[order[p]] == 1) ok = 0;
                if (m_id[order[p]] == m_id[s] && (m_st[order[p]] == 1 || m_st[order[p]] == 2)) ok = 0;
            end
            if (ok && sel_any < 0) sel_any = s;
            if (ok && m_ty[s] == 2 && sel_div < 0) sel_div = s;
        end
        hs      = m_iv && issue_ready;
        hs_slot = m_iidx;
        d       = int'(done_idx);
        r       = int'(release_idx);
        dn      = done_valid && d < SLOTS && m_st[d] == 1;
        rl      = release_valid && r < SLOTS && m_st[r] == 3;
        a       = lowest_free();
        ag      = alloc_req && a >= 0;

        if (m_iv) begin
            if (issue_ready) begin m_iv = 0; m_iidx = 0; end
        end else if (sel_div >= 0) begin
            m_iv = 1; m_iidx = sel_div;
        end else if (sel_any >= 0) begin
            m_iv = 1; m_iidx = sel_any;
        end else begin
            m_iidx = 0;
        end

        m_dv = 0; m_didx = 0;
        if (hs) m_st[hs_slot] = 3;
        if (dn) begin
            if (m_ty[d] == 3) begin
                m_st[d] = 0; model_remove(d); m_dv = 1; m_didx = d;
            end else begin
                m_st[d] = 2;
            end
        end
        if (rl) begin m_st[r] = 0; model_remove(r); end
        if (ag) begin
            m_st[a] = 1; m_id[a] = int'(alloc_id); m_ty[a] = int'(alloc_type);
            order.push_back(a);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    task automatic clr();
        alloc_req = 0; alloc_id = '0; alloc_type = '0;
        done_valid = 0; done_idx = '0; issue_ready = 0;
        release_valid = 0; release_idx = '0;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        nxt();
    endtask

    task automatic alloc1(input int ty, input int id);
        alloc_req = 1; alloc_type = TYPE_W'(ty); alloc_id = ID_W'(id);
        nxt();
        alloc_req = 0;
    endtask

    task automatic done1(input int idx);
        done_valid = 1; done_idx = IDX_W'(idx);
        nxt();
        done_valid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL reset_issue_valid got=%0b want=0", issue_valid); end
        total++; if (issue_idx !== 4'd0) begin bad++; $display("FAIL reset_issue_idx got=%0d want=0", issue_idx); end
        total++; if (drop_valid !== 1'b0) begin bad++; $display("FAIL reset_drop_valid got=%0b want=0", drop_valid); end
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occupancy got=%0d want=0", occupancy); end
        total++; if (full !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL reset_full_empty got=%0b%0b want=01", full, empty); end
        total++; if (alloc_gnt !== 1'b0) begin bad++; $display("FAIL reset_alloc_gnt got=%0b want=0", alloc_gnt); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int k = 0; k < SLOTS; k++) begin
            alloc_req = 1; alloc_type = 2'd0; alloc_id = ID_W'(k);
            #1;
            total++; if (alloc_gnt !== 1'b1 || alloc_idx !== IDX_W'(k)) begin
                bad++; $display("FAIL fill_grant k=%0d got gnt=%0b idx=%0d want gnt=1 idx=%0d", k, alloc_gnt, alloc_idx, k);
            end
            nxt();
        end
        alloc_req = 1;
        #1;
        total++; if (occupancy !== 3'd6 || full !== 1'b1 || empty !== 1'b0) begin
            bad++; $display("FAIL fill_full got occ=%0d full=%0b empty=%0b want occ=6 full=1 empty=0", occupancy, full, empty);
        end
        total++; if (alloc_gnt !== 1'b0 || alloc_idx !== 4'd0) begin
            bad++; $display("FAIL fill_seventh got gnt=%0b idx=%0d want gnt=0 idx=0", alloc_gnt, alloc_idx);
        end
        clr();
    endtask

    task automatic test_same_id();
        do_reset();
        alloc1(0, 3);
        alloc1(0, 3);
        done1(1);
        done1(0);
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL sameid_young_held got=%0b want=0", issue_valid); end
        nxt();
        total++; if (issue_valid !== 1'b1 || issue_idx !== 4'd0) begin
            bad++; $display("FAIL sameid_first got v=%0b idx=%0d want v=1 idx=0", issue_valid, issue_idx);
        end
        issue_ready = 1;
        nxt();
        issue_ready = 0;
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL sameid_gap got=%0b want=0", issue_valid); end
        nxt();
        total++; if (issue_valid !== 1'b1 || issue_idx !== 4'd1) begin
            bad++; $display("FAIL sameid_second got v=%0b idx=%0d want v=1 idx=1", issue_valid, issue_idx);
        end
    endtask

    task automatic test_block_divert();
        do_reset();
        alloc1(1, 5);
        alloc1(0, 1);
        alloc1(2, 2);
        done1(1);
        done1(2);
        done1(0);
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL fence_early got=%0b want=0", issue_valid); end
        nxt();
        total++; if (issue_valid !== 1'b1 || issue_idx !== 4'd0) begin
            bad++; $display("FAIL fence_block_first got v=%0b idx=%0d want v=1 idx=0", issue_valid, issue_idx);
        end
        issue_ready = 1;
        nxt();
        issue_ready = 0;
        for (int c = 0; c < 3; c++) begin
            total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL fence_hold c=%0d got=%0b want=0", c, issue_valid); end
            nxt();
        end
        release_valid = 1; release_idx = 4'd0;
        nxt();
        release_valid = 0;
        total++; if (issue_valid !== 1'b0 || occupancy !== 3'd2) begin
            bad++; $display("FAIL fence_release got v=%0b occ=%0d want v=0 occ=2", issue_valid, occupancy);
        end
        nxt();
        total++; if (issue_valid !== 1'b1 || issue_idx !== 4'd2) begin
            bad++; $display("FAIL divert_first got v=%0b idx=%0d want v=1 idx=2", issue_valid, issue_idx);
        end
        issue_ready = 1;
        nxt();
        issue_ready = 0;
        nxt();
        total++; if (issue_valid !== 1'b1 || issue_idx !== 4'd1) begin
            bad++; $display("FAIL divert_then_regular got v=%0b idx=%0d want v=1 idx=1", issue_valid, issue_idx);
        end
    endtask

    task automatic test_unlucky();
        do_reset();
        alloc1(0, 0);
        alloc1(0, 1);
        alloc1(3, 2);
        done1(2);
        total++; if (drop_valid !== 1'b1 || drop_idx !== 4'd2 || occupancy !== 3'd2) begin
            bad++; $display("FAIL unlucky_drop got v=%0b idx=%0d occ=%0d want v=1 idx=2 occ=2", drop_valid, drop_idx, occupancy);
        end
        nxt();
        total++; if (drop_valid !== 1'b0 || issue_valid !== 1'b0) begin
            bad++; $display("FAIL unlucky_one_shot got drop=%0b issue=%0b want 0 0", drop_valid, issue_valid);
        end
        alloc_req = 1; alloc_type = 2'd0; alloc_id = 4'd9;
        #1;
        total++; if (alloc_gnt !== 1'b1 || alloc_idx !== 4'd2) begin
            bad++; $display("FAIL unlucky_reuse got gnt=%0b idx=%0d want gnt=1 idx=2", alloc_gnt, alloc_idx);
        end
        clr();
    endtask

    task automatic test_hold_reset();
        do_reset();
        alloc1(0, 0);
        done1(0);
        nxt();
        for (int c = 0; c < 5; c++) begin
            if (c == 0) begin alloc_req = 1; alloc_type = 2'd2; alloc_id = 4'd7; end
            if (c == 1) begin done_valid = 1; done_idx = 4'd1; end
            nxt();
            clr();
            total++; if (issue_valid !== 1'b1 || issue_idx !== 4'd0) begin
                bad++; $display("FAIL hold c=%0d got v=%0b idx=%0d want v=1 idx=0", c, issue_valid, issue_idx);
            end
        end
        rst = 1'b1;
        #1;
        total++; if (issue_valid !== 1'b0 || issue_idx !== 4'd0 || drop_valid !== 1'b0 || drop_idx !== 4'd0) begin
            bad++; $display("FAIL midreset_issue got v=%0b idx=%0d drop=%0b want all 0", issue_valid, issue_idx, drop_valid);
        end
        total++; if (occupancy !== 3'd0 || full !== 1'b0 || empty !== 1'b1 || alloc_gnt !== 1'b0 || alloc_idx !== 4'd0) begin
            bad++; $display("FAIL midreset_occ got occ=%0d full=%0b empty=%0b gnt=%0b want occ=0 full=0 empty=1 gnt=0", occupancy, full, empty, alloc_gnt);
        end
        #2;
        rst = 1'b0;
        nxt();
        total++; if (issue_valid !== 1'b0 || occupancy !== 3'd0) begin
            bad++; $display("FAIL postreset got v=%0b occ=%0d want v=0 occ=0", issue_valid, occupancy);
        end
    endtask

    task automatic test_random();
        int fill_q[$];
        int iss_q[$];
        int exp_idx;
        bit exp_gnt;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            total++; if (issue_valid !== m_iv || (m_iv && issue_idx !== IDX_W'(m_iidx))) begin
                bad++; if (bad < 30) $display("FAIL rnd_issue cyc=%0d got v=%0b idx=%0d want v=%0b idx=%0d", cyc, issue_valid, issue_idx, m_iv, m_iidx);
            end
            total++; if (drop_valid !== m_dv || (m_dv && drop_idx !== IDX_W'(m_didx))) begin
                bad++; if (bad < 30) $display("FAIL rnd_drop cyc=%0d got v=%0b idx=%0d want v=%0b idx=%0d", cyc, drop_valid, drop_idx, m_dv, m_didx);
            end
            total++; if (occupancy !== 3'(order.size()) || full !== (order.size() == SLOTS) || empty !== (order.size() == 0)) begin
                bad++; if (bad < 30) $display("FAIL rnd_occ cyc=%0d got occ=%0d full=%0b empty=%0b want occ=%0d", cyc, occupancy, full, empty, order.size());
            end
            fill_q.delete();
            iss_q.delete();
            for (int s = 0; s < SLOTS; s++) begin
                if (m_st[s] == 1) fill_q.push_back(s);
                if (m_st[s] == 3) iss_q.push_back(s);
            end
            alloc_req  = ($urandom_range(99) < 45);
            alloc_type = TYPE_W'($urandom_range(3));
            alloc_id   = ID_W'($urandom_range(3));
            done_valid = ($urandom_range(99) < 55);
            if (fill_q.size() > 0 && $urandom_range(99) < 80)
                done_idx = IDX_W'(fill_q[$urandom_range(fill_q.size() - 1)]);
            else
                done_idx = IDX_W'($urandom_range(7));
            release_valid = ($urandom_range(99) < 45);
            if (iss_q.size() > 0 && $urandom_range(99) < 80)
                release_idx = IDX_W'(iss_q[$urandom_range(iss_q.size() - 1)]);
            else
                release_idx = IDX_W'($urandom_range(7));
            issue_ready = ($urandom_range(99) < 50);
            #1;
            exp_gnt = alloc_req && (order.size() < SLOTS);
            exp_idx = exp_gnt ? lowest_free() : 0;
            total++; if (alloc_gnt !== exp_gnt || alloc_idx !== IDX_W'(exp_idx)) begin
                bad++; if (bad < 30) $display("FAIL rnd_alloc cyc=%0d got gnt=%0b idx=%0d want gnt=%0b idx=%0d", cyc, alloc_gnt, alloc_idx, exp_gnt, exp_idx);
            end
            nxt();
        end
        clr();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        clr();
        test_reset();
        test_fill();
        test_same_id();
        test_block_divert();
        test_unlucky();
        test_hold_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spec_slot_sched.md
Name: spec_slot_sched

Overview:
Scheduler for the speculative write-burst slot pool: allocates one of SPEC_SLOT_AMOUNT slots per accepted AW, tracks data capture, and picks which completed slot the box master drains next. It enforces AXI same-ID ordering and the per-transaction type policy (REGULAR/BLOCK/DIVERT/UNLUCKY). It sits between the AW/W capture logic and the box master; it holds slot bookkeeping only, no burst data.

Parameters:
SLOTS, 6, number of speculative slots (SPEC_SLOT_AMOUNT)
ID_W, 4, AXI ID width (PID_WIDTH)
IDX_W, 4, slot index width (INDEX_WIDTH)
TYPE_W, 2, transaction type width (PAWUSER_WIDTH)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
alloc_req  in  1  request a slot for a new AW
alloc_id  in  ID_W  awid of the request
alloc_type  in  TYPE_W  awuser type: 00 REGULAR, 01 BLOCK, 10 DIVERT, 11 UNLUCKY
alloc_gnt  out  1  slot granted this cycle
alloc_idx  out  IDX_W  granted slot index
done_valid  in  1  all W beats of slot done_idx captured
done_idx  in  IDX_W  slot whose data completed
issue_valid  out  1  a slot is offered to the box master
issue_idx  out  IDX_W  offered slot
issue_ready  in  1  box master accepts the offered slot
release_valid  in  1  B response for slot release_idx returned
release_idx  in  IDX_W  slot to free
drop_valid  out  1  pulse: UNLUCKY slot discarded
drop_idx  out  IDX_W  discarded slot
occupancy  out  3  allocated slots, 0..SLOTS
full  out  1  occupancy == SLOTS
empty  out  1  occupancy == 0

Behaviour:
- Per-slot state: FREE -> FILLING (allocated) -> READY (done seen) -> ISSUED (handshake) -> FREE (release). Also stored: id, type, SLOTSxSLOTS age matrix (row i bit j = slot i older than slot j).
- Reset: all slots FREE; age matrix 0; all outputs 0; empty=1. Reset mid-operation discards every slot; no drop pulses.
- Allocation: alloc_gnt = alloc_req & ~full, combinational. alloc_idx = lowest-index FREE slot, 0 when no grant. The slot becomes FILLING at the next edge, marked younger than every occupied slot.
- Slots freed by release or drop in cycle N are allocatable from cycle N+1. No same-cycle bypass.
- done_valid for a slot not in FILLING is ignored. A READY UNLUCKY slot is never offered. It is freed at the edge after done and raises drop_valid/drop_idx for exactly one cycle, registered.
- Eligibility: slot is READY, type != UNLUCKY, no older slot with the same id is in FILLING or READY, and no older BLOCK slot is occupied.
- A BLOCK slot acts as a fence: nothing younger issues until the BLOCK slot is released.
- Selection: the oldest eligible DIVERT slot; otherwise the oldest eligible slot of any type.
- issue_valid/issue_idx are registered, computed from state one cycle earlier. Once issue_valid=1, issue_idx is held stable until issue_valid & issue_ready. The slot moves to ISSUED at that edge and issue_valid drops for at least one cycle.
- release_valid on a slot not in ISSUED is ignored.
- Simultaneous events on different slots all take effect in the same cycle.
- occupancy and full/empty are registered and updated on the same edge as slot state. Width is clog2(SLOTS+1).

Test Plan:
- Reset, then 6 alloc_req (REGULAR, ids 0..5) -> alloc_idx 0..5, full=1, occupancy=6. A 7th request gives alloc_gnt=0.
- Slots 0 (id 3), 1 (id 3) allocated; done slot 1 then slot 0 -> slot 0 issued first. Slot 1 is offered only after slot 0 becomes ISSUED.
- Slot 0 REGULAR, slot 1 DIVERT, both READY in the same cycle -> issue_idx=1 first.
- Slot 0 BLOCK, slot 1 REGULAR, both READY -> slot 0 issues. Slot 1 is offered only the cycle after release of slot 0.
- Slot 2 UNLUCKY, done -> one-cycle drop_valid with drop_idx=2, never offered, occupancy decrements. A next alloc gets idx 2 if it is the lowest free.
- issue_valid held 5 cycles with issue_ready=0 -> issue_idx constant. Assert rst mid-hold -> all outputs 0 immediately, empty=1.
